// File: rtl/fp_sched_pkg.sv
// Shared types for the floating-point worker arbiters (multiplier today, adder/divider later).
package fp_sched_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        FEED,
        WAIT_Z,
        RETURN
    } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // NOTE: both outputs get a default before the loop so no path leaves them unassigned (no latch).
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Scan from the farthest offset down so the one closest to ptr is written last and wins.
        for (int i = N - 1; i >= 0; i--) begin
            int j;
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (req[j]) begin
                valid = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one stb/ack floating-point worker between N_REQ requesters.
module mul_share_arbiter
    import fp_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  word_t [N_REQ-1:0]    req_a,
    input  word_t [N_REQ-1:0]    req_b,
    input  logic  [N_REQ-1:0]    req_stb,
    output logic  [N_REQ-1:0]    req_ack,
    output word_t                res_z,
    output logic  [N_REQ-1:0]    res_stb,
    input  logic  [N_REQ-1:0]    res_ack,
    output word_t                worker_a,
    output word_t                worker_b,
    output logic                 worker_a_stb,
    output logic                 worker_b_stb,
    input  logic                 worker_a_ack,
    input  logic                 worker_b_ack,
    input  word_t                worker_z,
    input  logic                 worker_z_stb,
    output logic                 worker_z_ack,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 busy
);

    sched_state_t     state;
    logic [IDX_W-1:0] ptr;
    logic             a_done;
    logic             b_done;
    word_t            z_reg;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             a_fire;
    logic             b_fire;

    rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (req_stb),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign a_fire = worker_a_stb && worker_a_ack;
    assign b_fire = worker_b_stb && worker_b_ack;

    // NOTE: every register here uses <= so all state updates see pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: datapath registers are reset too, so the buses read zero after reset rather than stale data.
            state        <= IDLE;
            ptr          <= '0;
            grant_idx    <= '0;
            busy         <= 1'b0;
            req_ack      <= '0;
            res_stb      <= '0;
            res_z        <= '0;
            worker_a     <= '0;
            worker_b     <= '0;
            worker_a_stb <= 1'b0;
            worker_b_stb <= 1'b0;
            worker_z_ack <= 1'b0;
            a_done       <= 1'b0;
            b_done       <= 1'b0;
            z_reg        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_idx <= pick_idx;
                        busy      <= 1'b1;
                        state     <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (req_ack[grant_idx] && req_stb[grant_idx]) begin
                        worker_a <= req_a[grant_idx];
                        worker_b <= req_b[grant_idx];
                        req_ack  <= '0;
                        state    <= FEED;
                    end else begin
                        req_ack[grant_idx] <= 1'b1;
                    end
                end
                FEED: begin
                    // The two operand channels finish independently; leave only once both have transferred.
                    if (a_fire) begin
                        worker_a_stb <= 1'b0;
                        a_done       <= 1'b1;
                    end else if (!a_done) begin
                        worker_a_stb <= 1'b1;
                    end
                    if (b_fire) begin
                        worker_b_stb <= 1'b0;
                        b_done       <= 1'b1;
                    end else if (!b_done) begin
                        worker_b_stb <= 1'b1;
                    end
                    if ((a_done || a_fire) && (b_done || b_fire)) begin
                        a_done <= 1'b0;
                        b_done <= 1'b0;
                        state  <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (worker_z_ack && worker_z_stb) begin
                        z_reg        <= worker_z;
                        worker_z_ack <= 1'b0;
                        state        <= RETURN;
                    end else begin
                        worker_z_ack <= 1'b1;
                    end
                end
                RETURN: begin
                    if (res_stb[grant_idx] && res_ack[grant_idx]) begin
                        res_stb <= '0;
                        ptr     <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        res_z              <= z_reg;
                        res_stb[grant_idx] <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A granted requester must keep its operands offered until they are accepted.
    grant_held_a: assert property (@(posedge clk) disable iff (!rst)
        (state == ACCEPT) |-> req_stb[grant_idx]);

    onehot_res_a: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(res_stb) && $onehot0(req_ack));

endmodule
